seat_request_loader: RTL

- Front-end initiator for the combinational seat allocator, which takes n plus candidate codes c1..c7 and returns seat results r1..r3.
- Accepts candidate codes serially over a valid/ready stream and assembles them into the allocator's parallel inputs.
- Waits a fixed settle time, then captures r1..r3.
- Returns the three seat results as a 3-beat valid/ready output stream, one frame at a time.

---
 rtl/seat_request_loader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/seat_request_loader.sv
// Serial-to-parallel front end for the combinational seat allocator: gathers up to seven
// candidate codes, lets the allocator settle, then streams its three seat results out.
module seat_request_loader #(
   parameter int W             = 4,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   input  logic         in_last,
   output logic [W-1:0] n,
   output logic [W-1:0] c1,
   output logic [W-1:0] c2,
   output logic [W-1:0] c3,
   output logic [W-1:0] c4,
   output logic [W-1:0] c5,
   output logic [W-1:0] c6,
   output logic [W-1:0] c7,
   input  logic [W-1:0] r1,
   input  logic [W-1:0] r2,
   input  logic [W-1:0] r3,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [1:0]   out_seat,
   output logic [W-1:0] out_data,
   output logic         out_last,
   output logic         busy
);

   typedef enum logic [1:0] {LOAD, SETTLE, EMIT} state_t;

   state_t              state_q, state_d;
   logic [2:0]          count_q, count_d;
   logic [W-1:0]        n_q, n_d;
   logic [6:0][W-1:0]   c_q, c_d;
   logic [3:0]          settle_q, settle_d;
   logic [2:0][W-1:0]   cap_q, cap_d;
   logic [1:0]          seat_q, seat_d;
   logic [2:0]          count_inc;
   logic                accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= LOAD;
         count_q  <= '0;
         n_q      <= '0;
         c_q      <= '0;
         settle_q <= '0;
         cap_q    <= '0;
         seat_q   <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         n_q      <= n_d;
         c_q      <= c_d;
         settle_q <= settle_d;
         cap_q    <= cap_d;
         seat_q   <= seat_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      n_d       = n_q;
      c_d       = c_q;
      settle_d  = settle_q;
      cap_d     = cap_q;
      seat_d    = seat_q;
      in_ready  = (state_q == LOAD) && (count_q < 3'd7);
      accept    = in_valid && in_ready;
      count_inc = count_q + 3'd1;

      case (state_q)
         LOAD: begin
            if (accept) begin
               c_d[count_q] = in_data;
               count_d      = count_inc;
               // The seventh code closes the frame even without in_last.
               if (in_last || (count_q == 3'd6)) begin
                  n_d      = W'(count_inc);
                  settle_d = '0;
                  state_d  = SETTLE;
               end
            end
         end
         SETTLE: begin
            settle_d = settle_q + 4'd1;
            if (settle_q == 4'(SETTLE_CYCLES - 1)) begin
               cap_d   = {r3, r2, r1};
               seat_d  = 2'd1;
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (out_ready) begin
               if (seat_q == 2'd3) begin
                  seat_d  = '0;
                  count_d = '0;
                  n_d     = '0;
                  c_d     = '0;
                  state_d = LOAD;
               end else begin
                  seat_d = seat_q + 2'd1;
               end
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_comb begin
      out_data = '0;
      if (state_q == EMIT) begin
         case (seat_q)
            2'd1:    out_data = cap_q[0];
            2'd2:    out_data = cap_q[1];
            2'd3:    out_data = cap_q[2];
            default: out_data = '0;
         endcase
      end
   end

   assign out_valid = (state_q == EMIT);
   assign out_seat  = seat_q;
   assign out_last  = (state_q == EMIT) && (seat_q == 2'd3);
   assign busy      = !((state_q == LOAD) && (count_q == 3'd0));
   assign n         = n_q;
   assign c1        = c_q[0];
   assign c2        = c_q[1];
   assign c3        = c_q[2];
   assign c4        = c_q[3];
   assign c5        = c_q[4];
   assign c6        = c_q[5];
   assign c7        = c_q[6];

endmodule
